// File: rtl/mips_pkg.sv
// Shared register-file definitions for the writeback slice: index and data
// widths, the hard-wired zero register and the load-return buffer entry.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Bundle of every non-clock signal of the writeback controller: ALU result,
// load issue, memory return handshake, decode hazard check and the register
// file write port. The master side drives requests, the slave is the controller.
interface reg_writeback_ctrl_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int ADDR_W     = mips_pkg::REG_ADDR_W
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              Alu_Valid;
    logic [ADDR_W-1:0] Alu_Dest;
    logic [DATA_W-1:0] Alu_Data;
    logic              Load_Issue;
    logic [ADDR_W-1:0] Load_Dest;
    logic              Mem_Valid;
    logic              Mem_Ready;
    logic [ADDR_W-1:0] Mem_Dest;
    logic [DATA_W-1:0] Mem_Data;
    logic [ADDR_W-1:0] Rs_Check;
    logic [ADDR_W-1:0] Rt_Check;
    logic              Hazard_Stall;
    logic              RegWrite;
    logic [ADDR_W-1:0] Write_register;
    logic [DATA_W-1:0] Write_Data;
    logic [CNT_W-1:0]  Pending_Count;
    logic              Error;

    modport master (
        output Alu_Valid, Alu_Dest, Alu_Data,
        output Load_Issue, Load_Dest,
        output Mem_Valid, Mem_Dest, Mem_Data,
        output Rs_Check, Rt_Check,
        input  Mem_Ready, Hazard_Stall,
        input  RegWrite, Write_register, Write_Data,
        input  Pending_Count, Error
    );

    modport slave (
        input  Alu_Valid, Alu_Dest, Alu_Data,
        input  Load_Issue, Load_Dest,
        input  Mem_Valid, Mem_Dest, Mem_Data,
        input  Rs_Check, Rt_Check,
        output Mem_Ready, Hazard_Stall,
        output RegWrite, Write_register, Write_Data,
        output Pending_Count, Error
    );

endinterface

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// Small synchronous FIFO holding load returns until the write port is free.
// The head is visible on rd_data without a read latency; occupancy is kept in
// a separate counter so the pointers can simply wrap.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wr_data,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses pushes even when a pop frees a slot on the same edge
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy update; simultaneous push and pop leaves count unchanged
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (!do_push && do_pop)
                count <= count - CNT_W'(1);
        end
    end

    // Storage array needs no reset; only slots behind the write pointer are read
    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Write-side initiator for the register file. ALU results take the single
// write port first; buffered load returns drain in order when the ALU is idle.
// A busy scoreboard tracks outstanding loads for decode stalls, writes to
// register zero are suppressed, and protocol violations raise a sticky Error.
module reg_writeback_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int ADDR_W     = mips_pkg::REG_ADDR_W
) (
    input logic                  CLK,
    input logic                  RESET,
    reg_writeback_ctrl_if.slave  bus
);

    import mips_pkg::*;

    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int NREG  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENT_W-1:0]  head;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_next;
    logic              alu_waw;
    logic              bad_return;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({bus.Mem_Dest, bus.Mem_Data}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (bus.Pending_Count)
    );

    assign {head_dest, head_data} = head;

    assign fifo_push     = bus.Mem_Valid && !fifo_full;
    assign fifo_pop      = !bus.Alu_Valid && !fifo_empty;
    assign bus.Mem_Ready = !fifo_full;

    assign bus.Hazard_Stall = busy[bus.Rs_Check] | busy[bus.Rt_Check];

    assign alu_waw    = bus.Alu_Valid && (bus.Alu_Dest != ZERO_IDX) && busy[bus.Alu_Dest];
    assign bad_return = fifo_push && (bus.Mem_Dest != ZERO_IDX) && !busy[bus.Mem_Dest];

    // Scoreboard next state: retire the popped load, then mark the new issue so set wins
    always_comb begin
        busy_next = busy;
        if (fifo_pop)
            busy_next[head_dest] = 1'b0;
        if (bus.Load_Issue)
            busy_next[bus.Load_Dest] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge CLK) begin
        if (RESET)
            busy <= '0;
        else
            busy <= busy_next;
    end

    // Write port registers: ALU first, else FIFO head, else idle holding index and data
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bus.RegWrite       <= 1'b0;
            bus.Write_register <= '0;
            bus.Write_Data     <= '0;
        end else if (bus.Alu_Valid) begin
            bus.RegWrite       <= (bus.Alu_Dest != ZERO_IDX);
            bus.Write_register <= bus.Alu_Dest;
            bus.Write_Data     <= bus.Alu_Data;
        end else if (fifo_pop) begin
            bus.RegWrite       <= (head_dest != ZERO_IDX);
            bus.Write_register <= head_dest;
            bus.Write_Data     <= head_data;
        end else begin
            bus.RegWrite       <= 1'b0;
        end
    end

    // Sticky protocol-violation flag, cleared only by reset
    always_ff @(posedge CLK) begin
        if (RESET)
            bus.Error <= 1'b0;
        else if (alu_waw || bad_return)
            bus.Error <= 1'b1;
    end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench for reg_writeback_ctrl: directed scenarios followed by a
// randomized run compared against a queue-based reference model.
module tb_reg_writeback_ctrl;

    import mips_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic CLK;
    logic RESET;
    int   tests;
    int   fails;

    reg_writeback_ctrl_if #(.FIFO_DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) bus ();

    reg_writeback_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Free-running clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "[TB] timeout");
    end

    // Reference model state
    wb_entry_t   q_m[$];
    bit [31:0]   busy_m;
    bit          err_m;
    bit          rw_m;
    bit [4:0]    wr_m;
    bit [31:0]   wd_m;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.Alu_Valid  = 1'b0;
        bus.Alu_Dest   = '0;
        bus.Alu_Data   = '0;
        bus.Load_Issue = 1'b0;
        bus.Load_Dest  = '0;
        bus.Mem_Valid  = 1'b0;
        bus.Mem_Dest   = '0;
        bus.Mem_Data   = '0;
        bus.Rs_Check   = '0;
        bus.Rt_Check   = '0;
    endtask

    task automatic test_reset();
        idle();
        RESET = 1'b1;
        tick();
        tick();
        bus.Rs_Check = 5'd5;
        #1;
        tests++; if (bus.RegWrite !== 1'b0) begin fails++; $display("[TB] FAIL rst_we: got %0b want 0", bus.RegWrite); end
        tests++; if (bus.Write_register !== 5'd0) begin fails++; $display("[TB] FAIL rst_wr: got %0d want 0", bus.Write_register); end
        tests++; if (bus.Write_Data !== 32'd0) begin fails++; $display("[TB] FAIL rst_wd: got %0h want 0", bus.Write_Data); end
        tests++; if (bus.Mem_Ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_ready: got %0b want 1", bus.Mem_Ready); end
        tests++; if (bus.Pending_Count !== 3'd0) begin fails++; $display("[TB] FAIL rst_count: got %0d want 0", bus.Pending_Count); end
        tests++; if (bus.Hazard_Stall !== 1'b0) begin fails++; $display("[TB] FAIL rst_stall: got %0b want 0", bus.Hazard_Stall); end
        tests++; if (bus.Error !== 1'b0) begin fails++; $display("[TB] FAIL rst_err: got %0b want 0", bus.Error); end
        RESET = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_alu_write();
        bus.Alu_Valid = 1'b1;
        bus.Alu_Dest  = 5'd8;
        bus.Alu_Data  = 32'h0000002A;
        tick();
        tests++; if (bus.RegWrite !== 1'b1) begin fails++; $display("[TB] FAIL alu_we: got %0b want 1", bus.RegWrite); end
        tests++; if (bus.Write_register !== 5'd8) begin fails++; $display("[TB] FAIL alu_wr: got %0d want 8", bus.Write_register); end
        tests++; if (bus.Write_Data !== 32'h2A) begin fails++; $display("[TB] FAIL alu_wd: got %0h want 2a", bus.Write_Data); end
        bus.Alu_Dest = 5'd0;
        bus.Alu_Data = 32'h55;
        tick();
        tests++; if (bus.RegWrite !== 1'b0) begin fails++; $display("[TB] FAIL alu_zero_we: got %0b want 0", bus.RegWrite); end
        idle();
        tick();
        tests++; if (bus.RegWrite !== 1'b0) begin fails++; $display("[TB] FAIL alu_idle_we: got %0b want 0", bus.RegWrite); end
    endtask

    task automatic test_load_stall();
        bus.Load_Issue = 1'b1;
        bus.Load_Dest  = 5'd9;
        tick();
        bus.Load_Issue = 1'b0;
        bus.Rs_Check   = 5'd9;
        #1;
        tests++; if (bus.Hazard_Stall !== 1'b1) begin fails++; $display("[TB] FAIL ld_stall_set: got %0b want 1", bus.Hazard_Stall); end
        bus.Mem_Valid = 1'b1;
        bus.Mem_Dest  = 5'd9;
        bus.Mem_Data  = 32'hDEADBEEF;
        tick();
        bus.Mem_Valid = 1'b0;
        #1;
        tests++; if (bus.RegWrite !== 1'b0) begin fails++; $display("[TB] FAIL ld_no_bypass: got %0b want 0", bus.RegWrite); end
        tests++; if (bus.Pending_Count !== 3'd1) begin fails++; $display("[TB] FAIL ld_count: got %0d want 1", bus.Pending_Count); end
        tests++; if (bus.Hazard_Stall !== 1'b1) begin fails++; $display("[TB] FAIL ld_stall_hold: got %0b want 1", bus.Hazard_Stall); end
        tick();
        tests++; if (bus.RegWrite !== 1'b1) begin fails++; $display("[TB] FAIL ld_we: got %0b want 1", bus.RegWrite); end
        tests++; if (bus.Write_register !== 5'd9) begin fails++; $display("[TB] FAIL ld_wr: got %0d want 9", bus.Write_register); end
        tests++; if (bus.Write_Data !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL ld_wd: got %0h want deadbeef", bus.Write_Data); end
        tests++; if (bus.Hazard_Stall !== 1'b0) begin fails++; $display("[TB] FAIL ld_stall_clear: got %0b want 0", bus.Hazard_Stall); end
        tests++; if (bus.Error !== 1'b0) begin fails++; $display("[TB] FAIL ld_err: got %0b want 0", bus.Error); end
        idle();
        tick();
    endtask

    task automatic test_alu_priority();
        bit [4:0]  exp_wr [4];
        bit [31:0] exp_wd [4];
        exp_wr = '{5'd12, 5'd12, 5'd10, 5'd11};
        exp_wd = '{32'h3, 32'h3, 32'h1, 32'h2};
        bus.Load_Issue = 1'b1;
        bus.Load_Dest  = 5'd10;
        tick();
        bus.Load_Dest  = 5'd11;
        tick();
        bus.Load_Issue = 1'b0;
        bus.Alu_Valid  = 1'b1;
        bus.Alu_Dest   = 5'd12;
        bus.Alu_Data   = 32'h3;
        bus.Mem_Valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin bus.Mem_Dest = 5'd10; bus.Mem_Data = 32'h1; end
            if (i == 1) begin bus.Mem_Dest = 5'd11; bus.Mem_Data = 32'h2; end
            if (i == 2) begin bus.Alu_Valid = 1'b0; bus.Mem_Valid = 1'b0; end
            tick();
            tests++; if (bus.RegWrite !== 1'b1) begin fails++; $display("[TB] FAIL prio_we[%0d]: got %0b want 1", i, bus.RegWrite); end
            tests++; if (bus.Write_register !== exp_wr[i]) begin fails++; $display("[TB] FAIL prio_wr[%0d]: got %0d want %0d", i, bus.Write_register, exp_wr[i]); end
            tests++; if (bus.Write_Data !== exp_wd[i]) begin fails++; $display("[TB] FAIL prio_wd[%0d]: got %0h want %0h", i, bus.Write_Data, exp_wd[i]); end
        end
        tests++; if (bus.Error !== 1'b0) begin fails++; $display("[TB] FAIL prio_err: got %0b want 0", bus.Error); end
        idle();
        tick();
    endtask

    task automatic test_full_boundary();
        bus.Load_Issue = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.Load_Dest = 5'(16 + i);
            tick();
        end
        bus.Load_Issue = 1'b0;
        bus.Alu_Valid  = 1'b1;
        bus.Alu_Dest   = 5'd21;
        bus.Alu_Data   = 32'h77;
        bus.Mem_Valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.Mem_Dest = 5'(16 + i);
            bus.Mem_Data = 32'h100 + 32'(i);
            tick();
        end
        tests++; if (bus.Pending_Count !== 3'd4) begin fails++; $display("[TB] FAIL full_count: got %0d want 4", bus.Pending_Count); end
        tests++; if (bus.Mem_Ready !== 1'b0) begin fails++; $display("[TB] FAIL full_ready: got %0b want 0", bus.Mem_Ready); end
        bus.Mem_Dest = 5'd20;
        bus.Mem_Data = 32'h999;
        tick();
        tests++; if (bus.Pending_Count !== 3'd4) begin fails++; $display("[TB] FAIL full_reject: got %0d want 4", bus.Pending_Count); end
        tests++; if (bus.Error !== 1'b0) begin fails++; $display("[TB] FAIL full_err: got %0b want 0", bus.Error); end
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (bus.RegWrite !== 1'b1) begin fails++; $display("[TB] FAIL drain_we[%0d]: got %0b want 1", i, bus.RegWrite); end
            tests++; if (bus.Write_register !== 5'(16 + i)) begin fails++; $display("[TB] FAIL drain_wr[%0d]: got %0d want %0d", i, bus.Write_register, 16 + i); end
            tests++; if (bus.Write_Data !== 32'h100 + 32'(i)) begin fails++; $display("[TB] FAIL drain_wd[%0d]: got %0h want %0h", i, bus.Write_Data, 32'h100 + i); end
            tests++; if (bus.Pending_Count !== CNT_W'(3 - i)) begin fails++; $display("[TB] FAIL drain_count[%0d]: got %0d want %0d", i, bus.Pending_Count, 3 - i); end
            tests++; if (bus.Mem_Ready !== 1'b1) begin fails++; $display("[TB] FAIL drain_ready[%0d]: got %0b want 1", i, bus.Mem_Ready); end
        end
        tick();
        tests++; if (bus.RegWrite !== 1'b0) begin fails++; $display("[TB] FAIL drain_done_we: got %0b want 0", bus.RegWrite); end
    endtask

    task automatic test_errors_and_reset();
        bus.Load_Issue = 1'b1;
        bus.Load_Dest  = 5'd13;
        tick();
        bus.Load_Issue = 1'b0;
        bus.Alu_Valid  = 1'b1;
        bus.Alu_Dest   = 5'd13;
        bus.Alu_Data   = 32'hABC;
        tick();
        tests++; if (bus.RegWrite !== 1'b1 || bus.Write_register !== 5'd13) begin fails++; $display("[TB] FAIL waw_write: got we=%0b wr=%0d want we=1 wr=13", bus.RegWrite, bus.Write_register); end
        tests++; if (bus.Error !== 1'b1) begin fails++; $display("[TB] FAIL waw_err: got %0b want 1", bus.Error); end
        idle();
        tick();
        tick();
        tests++; if (bus.Error !== 1'b1) begin fails++; $display("[TB] FAIL err_sticky: got %0b want 1", bus.Error); end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        bus.Mem_Valid = 1'b1;
        bus.Mem_Dest  = 5'd14;
        bus.Mem_Data  = 32'h14;
        tick();
        bus.Mem_Valid = 1'b0;
        tests++; if (bus.Error !== 1'b1) begin fails++; $display("[TB] FAIL unexp_err: got %0b want 1", bus.Error); end
        tick();
        bus.Load_Issue = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.Load_Dest = 5'(i);
            tick();
        end
        bus.Load_Issue = 1'b0;
        bus.Alu_Valid  = 1'b1;
        bus.Alu_Dest   = 5'd4;
        bus.Mem_Valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.Mem_Dest = 5'(i);
            tick();
        end
        tests++; if (bus.Pending_Count !== 3'd3) begin fails++; $display("[TB] FAIL buf3_count: got %0d want 3", bus.Pending_Count); end
        idle();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        bus.Rs_Check = 5'd1;
        bus.Rt_Check = 5'd2;
        #1;
        tests++; if (bus.Pending_Count !== 3'd0) begin fails++; $display("[TB] FAIL midrst_count: got %0d want 0", bus.Pending_Count); end
        tests++; if (bus.Hazard_Stall !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %0b want 0", bus.Hazard_Stall); end
        tests++; if (bus.Error !== 1'b0) begin fails++; $display("[TB] FAIL midrst_err: got %0b want 0", bus.Error); end
        tick();
        tests++; if (bus.RegWrite !== 1'b0) begin fails++; $display("[TB] FAIL midrst_we: got %0b want 0", bus.RegWrite); end
        idle();
    endtask

    task automatic test_random();
        int        cands[$];
        wb_entry_t h;
        wb_entry_t e;
        bit        rst, alu_v, ld_i, mem_v, full_m, push_m;
        bit [4:0]  alu_d, ld_d, mem_d, rs, rt;
        bit [31:0] alu_dat, mem_dat;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst     = (cyc == 0) || ($urandom_range(0, 99) == 0);
            alu_v   = ($urandom_range(0, 99) < 35);
            alu_d   = 5'($urandom_range(0, 31));
            if (busy_m[alu_d] && $urandom_range(0, 19) != 0)
                alu_d = 5'd0;
            alu_dat = $urandom;
            ld_i    = ($urandom_range(0, 99) < 30);
            ld_d    = 5'($urandom_range(0, 31));
            cands.delete();
            for (int r = 1; r < 32; r++)
                if (busy_m[r]) cands.push_back(r);
            mem_v   = ($urandom_range(0, 99) < 45);
            if (cands.size() > 0 && $urandom_range(0, 19) != 0)
                mem_d = 5'(cands[$urandom_range(0, cands.size() - 1)]);
            else
                mem_d = 5'($urandom_range(0, 31));
            mem_dat = $urandom;
            rs      = 5'($urandom_range(0, 31));
            rt      = 5'($urandom_range(0, 31));

            RESET          = rst;
            bus.Alu_Valid  = alu_v;
            bus.Alu_Dest   = alu_d;
            bus.Alu_Data   = alu_dat;
            bus.Load_Issue = ld_i;
            bus.Load_Dest  = ld_d;
            bus.Mem_Valid  = mem_v;
            bus.Mem_Dest   = mem_d;
            bus.Mem_Data   = mem_dat;
            bus.Rs_Check   = rs;
            bus.Rt_Check   = rt;
            #1;
            if (cyc > 0) begin
                tests++; if (bus.Mem_Ready !== (q_m.size() < DEPTH)) begin fails++; $display("[TB] FAIL rnd_ready@%0d: got %0b want %0b", cyc, bus.Mem_Ready, q_m.size() < DEPTH); end
                tests++; if (bus.Hazard_Stall !== (busy_m[rs] | busy_m[rt])) begin fails++; $display("[TB] FAIL rnd_stall@%0d: got %0b want %0b", cyc, bus.Hazard_Stall, busy_m[rs] | busy_m[rt]); end
            end

            if (rst) begin
                q_m.delete();
                busy_m = '0;
                err_m  = 1'b0;
                rw_m   = 1'b0;
                wr_m   = '0;
                wd_m   = '0;
            end else begin
                full_m = (q_m.size() == DEPTH);
                push_m = mem_v && !full_m;
                if (alu_v && alu_d != 0 && busy_m[alu_d]) err_m = 1'b1;
                if (push_m && mem_d != 0 && !busy_m[mem_d]) err_m = 1'b1;
                if (alu_v) begin
                    rw_m = (alu_d != 0);
                    wr_m = alu_d;
                    wd_m = alu_dat;
                end else if (q_m.size() > 0) begin
                    h = q_m.pop_front();
                    rw_m = (h.dest != 0);
                    wr_m = h.dest;
                    wd_m = h.data;
                    busy_m[h.dest] = 1'b0;
                end else begin
                    rw_m = 1'b0;
                end
                if (push_m) begin
                    e.dest = mem_d;
                    e.data = mem_dat;
                    q_m.push_back(e);
                end
                if (ld_i) busy_m[ld_d] = 1'b1;
                busy_m[0] = 1'b0;
            end

            tick();
            tests++; if (bus.RegWrite !== rw_m) begin fails++; $display("[TB] FAIL rnd_we@%0d: got %0b want %0b", cyc, bus.RegWrite, rw_m); end
            if (rw_m || rst) begin
                tests++; if (bus.Write_register !== wr_m) begin fails++; $display("[TB] FAIL rnd_wr@%0d: got %0d want %0d", cyc, bus.Write_register, wr_m); end
                tests++; if (bus.Write_Data !== wd_m) begin fails++; $display("[TB] FAIL rnd_wd@%0d: got %0h want %0h", cyc, bus.Write_Data, wd_m); end
            end
            tests++; if (bus.Pending_Count !== CNT_W'(q_m.size())) begin fails++; $display("[TB] FAIL rnd_count@%0d: got %0d want %0d", cyc, bus.Pending_Count, q_m.size()); end
            tests++; if (bus.Error !== err_m) begin fails++; $display("[TB] FAIL rnd_err@%0d: got %0b want %0b", cyc, bus.Error, err_m); end
        end
        RESET = 1'b0;
        idle();
    endtask

    // Scenario sequence and summary
    initial begin
        tests = 0;
        fails = 0;
        RESET = 1'b1;
        idle();
        #1;
        test_reset();
        test_alu_write();
        test_load_stall();
        test_alu_priority();
        test_full_boundary();
        test_errors_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
